// File: rtl/weight_tile_loader.sv
// Packs ROWS weight beats into ping-pong tile banks and presents each full tile
// to the systolic array preload port; pulses layer_done after the configured tile count.
module weight_tile_loader #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned ROWS   = 16,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     s_axis_wlconfig_tvalid,
  output logic                     s_axis_wlconfig_tready,
  input  logic [31:0]              s_axis_wlconfig_tdata,
  input  logic                     s_axis_weight_tvalid,
  output logic                     s_axis_weight_tready,
  input  logic [DATA_W-1:0]        s_axis_weight_tdata,
  output logic                     m_tile_valid,
  input  logic                     m_tile_ready,
  output logic [ROWS*DATA_W-1:0]   m_tile_data,
  output logic                     layer_done,
  output logic [3:0]               status_wl
);

  localparam int unsigned ROW_W  = (ROWS > 1) ? $clog2(ROWS) : 1;
  localparam int unsigned TILE_W = ROWS * DATA_W;
  localparam int unsigned CMP_W  = CNT_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  logic [1:0]       state, state_nxt;
  logic             cfg_ready, cfg_ready_nxt;
  logic [CNT_W-1:0] tile_num, tile_cnt, wr_tiles;
  logic [ROW_W-1:0] row_cnt;
  logic             wr_bank, rd_bank;
  logic [1:0]       full;
  logic [TILE_W-1:0] bank [2];
  logic             cfg_fire, wr_fire, wr_last, rd_fire, last_rd;
  logic             unused_cfg_bits;

  assign unused_cfg_bits = ^s_axis_wlconfig_tdata[31:CNT_W];

  // Handshake decode; every ready/valid here is derived from registers only.
  assign s_axis_wlconfig_tready = cfg_ready;
  assign cfg_fire               = s_axis_wlconfig_tvalid & cfg_ready;
  assign s_axis_weight_tready   = (state == S_RUN) & ~full[wr_bank] & (wr_tiles < tile_num);
  assign wr_fire                = s_axis_weight_tvalid & s_axis_weight_tready;
  assign wr_last                = wr_fire & (row_cnt == ROW_W'(ROWS - 1));
  assign m_tile_valid           = full[rd_bank];
  assign rd_fire                = m_tile_valid & m_tile_ready;
  assign last_rd                = rd_fire &
                                  ((CMP_W'(tile_cnt) + CMP_W'(1)) == CMP_W'(tile_num));
  assign m_tile_data            = bank[rd_bank];
  assign layer_done             = (state == S_DONE);
  assign status_wl              = {2'b00, state};

  // State register; config ready is registered so it stays low through reset release.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cfg_ready <= 1'b0;
    end else begin
      state     <= state_nxt;
      cfg_ready <= cfg_ready_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    cfg_ready_nxt = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_fire) begin
          state_nxt = (s_axis_wlconfig_tdata[CNT_W-1:0] == '0) ? S_DONE : S_RUN;
        end
      end
      S_RUN: begin
        if (last_rd) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
    cfg_ready_nxt = (state_nxt == S_IDLE);
  end

  // Bank bookkeeping; a completing write and a freeing read always target different banks.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tile_num <= '0;
      tile_cnt <= '0;
      wr_tiles <= '0;
      row_cnt  <= '0;
      wr_bank  <= 1'b0;
      rd_bank  <= 1'b0;
      full     <= 2'b00;
    end else begin
      if (cfg_fire) begin
        tile_num <= s_axis_wlconfig_tdata[CNT_W-1:0];
      end
      if (state == S_DONE) begin
        tile_cnt <= '0;
        wr_tiles <= '0;
        row_cnt  <= '0;
        wr_bank  <= 1'b0;
        rd_bank  <= 1'b0;
      end else begin
        if (wr_fire) begin
          row_cnt <= wr_last ? '0 : row_cnt + 1'b1;
          if (wr_last) begin
            full[wr_bank] <= 1'b1;
            wr_bank       <= ~wr_bank;
            wr_tiles      <= wr_tiles + 1'b1;
          end
        end
        if (rd_fire) begin
          full[rd_bank] <= 1'b0;
          rd_bank       <= ~rd_bank;
          tile_cnt      <= tile_cnt + 1'b1;
        end
      end
    end
  end

  // Tile storage: beat r lands in row slice r of the active write bank.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bank[0] <= '0;
      bank[1] <= '0;
    end else if (wr_fire) begin
      for (int r = 0; r < ROWS; r++) begin
        if (row_cnt == ROW_W'(r)) begin
          bank[wr_bank][r*DATA_W +: DATA_W] <= s_axis_weight_tdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_weight_tile_loader.sv
// Self-checking bench for weight_tile_loader: directed and random layers compared
// against a tile/occupancy reference model.
module tb_weight_tile_loader;

  localparam int unsigned DATA_W = 128;
  localparam int unsigned ROWS   = 16;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned TILE_W = ROWS * DATA_W;
  localparam int          NSRC   = 64;

  logic              clk;
  logic              rst_n;
  logic              cfg_valid;
  logic              cfg_tready;
  logic [31:0]       cfg_data;
  logic              w_valid;
  logic              w_tready;
  logic [DATA_W-1:0] w_data;
  logic              t_valid;
  logic              t_ready;
  logic [TILE_W-1:0] t_data;
  logic              done;
  logic [3:0]        status;

  int n_tests = 0;
  int n_fail  = 0;
  logic [DATA_W-1:0] src [NSRC];

  weight_tile_loader #(.DATA_W(DATA_W), .ROWS(ROWS), .CNT_W(CNT_W)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .s_axis_wlconfig_tvalid (cfg_valid),
    .s_axis_wlconfig_tready (cfg_tready),
    .s_axis_wlconfig_tdata  (cfg_data),
    .s_axis_weight_tvalid   (w_valid),
    .s_axis_weight_tready   (w_tready),
    .s_axis_weight_tdata    (w_data),
    .m_tile_valid           (t_valid),
    .m_tile_ready           (t_ready),
    .m_tile_data            (t_data),
    .layer_done             (done),
    .status_wl              (status)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [DATA_W-1:0] got,
                           input logic [DATA_W-1:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic fill_src(input int mode);
    for (int i = 0; i < NSRC; i++) begin
      if (mode == 0) src[i] = {8{16'(i)}};
      else           src[i] = {$urandom(), $urandom(), $urandom(), $urandom()};
    end
  endtask

  task automatic check_all_zero(input string tag);
    check_val({tag, "_cfg_ready"}, DATA_W'(cfg_tready), '0);
    check_val({tag, "_w_ready"},   DATA_W'(w_tready),   '0);
    check_val({tag, "_t_valid"},   DATA_W'(t_valid),    '0);
    check_val({tag, "_done"},      DATA_W'(done),       '0);
    check_val({tag, "_status"},    DATA_W'(status),     '0);
    check_val({tag, "_t_data"},    DATA_W'(|t_data),    '0);
  endtask

  // Model: tiles are consecutive groups of ROWS offered beats; at most two tiles buffered.
  // vmode: 0 = valid whenever beats remain, 1 = random valid.
  // rmode: 0 = ready high, 1 = random, 2 = single pulse at cycle 40 then high from 60,
  //        3 = ready only while beat 31 is offered, then high from cycle 70.
  task automatic run_layer(input int tnum, input int offered, input int vmode,
                           input int rmode, input int abort_at);
    int  wr_beats, wr_tiles, rd_tiles, cyc, tail, k, exp_acc, idx;
    bit  running, done_exp, done_nxt, exp_rdy;
    logic wfire, rfire;
    wr_beats = 0; wr_tiles = 0; rd_tiles = 0; cyc = 0; tail = 0; k = 0;

    @(negedge clk);
    w_valid   = 1'b0;
    t_ready   = 1'b0;
    cfg_valid = 1'b1;
    cfg_data  = {16'($urandom()), 16'(tnum)};
    while (!cfg_tready && k < 20) begin
      @(negedge clk);
      k++;
    end
    check_val("cfg_ready_idle", DATA_W'(cfg_tready), DATA_W'(1));
    check_val("w_ready_idle",   DATA_W'(w_tready),   '0);

    running  = (tnum > 0);
    done_exp = (tnum == 0);
    done_nxt = 1'b0;

    while (cyc < 3000) begin
      @(negedge clk);
      cfg_valid = 1'b0;
      w_valid   = (wr_beats < offered) && (vmode == 0 || $urandom_range(0, 3) != 0);
      w_data    = (wr_beats < offered && wr_beats < NSRC) ? src[wr_beats] : '0;
      case (rmode)
        0:       t_ready = 1'b1;
        1:       t_ready = 1'($urandom_range(0, 1));
        2:       t_ready = (cyc == 40) || (cyc >= 60);
        default: t_ready = (wr_beats == 31) || (cyc >= 70);
      endcase

      exp_rdy = running && (wr_tiles - rd_tiles < 2) && (wr_tiles < tnum);
      check_val("w_ready",   DATA_W'(w_tready),   DATA_W'(exp_rdy));
      check_val("t_valid",   DATA_W'(t_valid),    DATA_W'(running && wr_tiles > rd_tiles));
      check_val("layer_done", DATA_W'(done),      DATA_W'(done_exp));
      check_val("status",    DATA_W'(status),     DATA_W'(done_exp ? 2 : (running ? 1 : 0)));
      check_val("cfg_ready", DATA_W'(cfg_tready), DATA_W'(!running && !done_exp));

      wfire = w_valid & w_tready;
      rfire = t_valid & t_ready;
      if (rfire) begin
        for (int r = 0; r < ROWS; r++) begin
          idx = rd_tiles * ROWS + r;
          check_val($sformatf("tile%0d_row%0d", rd_tiles, r), t_data[r*DATA_W +: DATA_W],
                    (idx < NSRC) ? src[idx] : '0);
        end
        rd_tiles++;
        if (rd_tiles == tnum) begin
          running  = 1'b0;
          done_nxt = 1'b1;
        end
      end
      if (wfire) begin
        wr_beats++;
        if (wr_beats % ROWS == 0) wr_tiles++;
      end
      done_exp = done_nxt;
      done_nxt = 1'b0;

      if (abort_at >= 0 && wr_beats == abort_at) return;
      if (!running && !done_exp) begin
        tail++;
        if (tail > 5) break;
      end
      cyc++;
    end

    exp_acc = (offered < tnum * ROWS) ? offered : tnum * ROWS;
    check_val("layer_finished", DATA_W'(running || done_exp), '0);
    check_val("beats_accepted", DATA_W'(wr_beats), DATA_W'(exp_acc));
    check_val("tiles_read",     DATA_W'(rd_tiles), DATA_W'(tnum));
    w_valid = 1'b0;
    t_ready = 1'b0;
  endtask

  initial begin
    int tn, off;
    rst_n     = 1'b0;
    cfg_valid = 1'b0;
    cfg_data  = '0;
    w_valid   = 1'b0;
    w_data    = '0;
    t_ready   = 1'b0;
    #1;
    check_all_zero("rst_hold");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all_zero("rst_release");

    fill_src(0);
    run_layer(2, 32, 0, 0, -1);
    fill_src(0);
    run_layer(3, 48, 0, 2, -1);
    fill_src(1);
    run_layer(4, 64, 0, 3, -1);
    fill_src(1);
    run_layer(1, 20, 0, 0, -1);
    run_layer(0, 16, 0, 0, -1);

    // Asynchronous reset partway through the second tile.
    fill_src(0);
    run_layer(2, 32, 0, 0, 24);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_all_zero("rst_async");
    w_valid = 1'b0;
    t_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_all_zero("rst_after");
    fill_src(1);
    run_layer(1, 16, 0, 0, -1);

    for (int l = 0; l < 5; l++) begin
      tn  = $urandom_range(1, 4);
      off = tn * ROWS + ((tn < 4) ? $urandom_range(0, 4) : 0);
      fill_src(1);
      run_layer(tn, off, 1, 1, -1);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
